s_cska12_frame_accum: RTL and testbench
=======================================

Name: s_cska12_frame_accum

Overview:
- Sequential consumer placed directly downstream of the 12-bit signed carry-skip adder.
- Takes the adder's 13-bit signed sum through a valid/ready handshake and accumulates ACC_LEN consecutive sums into an ACC_W-bit signed register.
- Presents each completed frame total downstream through a second valid/ready handshake.
- Used for windowed sum and average datapaths built on the generated adders.

Parameters:
- IN_W, 13, width of signed input sum (adder output width).
- ACC_W, 16, width of signed accumulator and frame output.
- ACC_LEN, 16, samples per frame; legal range 1..255.
- CNT_W, 8, width of sample counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous frame abort: drops partial or pending frame.
- sum_in  input  IN_W  signed two's-complement sum from adder.
- in_valid  input  1  sum_in is valid this cycle.
- in_ready  output  1  block accepts a sample this cycle.
- acc_out  output  ACC_W  signed frame total; stable while out_valid=1.
- out_valid  output  1  completed frame available.
- out_ready  input  1  downstream accepts acc_out.
- sample_cnt  output  CNT_W  samples accepted in current frame.
- ovf  output  1  sticky per-frame flag: accumulation left the ACC_W signed range.

Behaviour:
- Reset values (rst=1 at an edge): state=ACCUM, acc=0, sample_cnt=0, acc_out=0, out_valid=0, ovf=0. in_ready is driven as 1 the cycle after reset.
- States: ACCUM, HOLD.
- ACCUM behaviour:
  - in_ready=1, out_valid=0.
  - Accept when in_valid=1: acc <= acc + sign_extend(sum_in) and sample_cnt <= sample_cnt+1.
  - When the accepted sample is number ACC_LEN: acc_out <= final total, state <= HOLD, out_valid=1 from the next cycle. acc and sample_cnt clear to 0 on that same edge.
- HOLD behaviour:
  - in_ready=0, out_valid=1, acc_out held.
  - out_valid && out_ready at an edge: out_valid <= 0, ovf <= 0, state <= ACCUM.
  - A new frame may start on the cycle after the handshake. There is no overlap: at most one frame is buffered.
- Latency: out_valid rises 1 cycle after the edge that accepts the last sample. Minimum frame period is ACC_LEN+1 cycles when out_ready is held at 1.
- Arithmetic:
  - Signed add at ACC_W+1 bits.
  - Overflow is detected when the ACC_W+1 result differs from the sign-extension of its low ACC_W bits. ovf is set on detection and stays set until the frame is consumed or cleared.
  - Default mode wraps: low ACC_W bits are kept.
- clear=1:
  - Next state is ACCUM with acc=0, sample_cnt=0, out_valid=0, ovf=0.
  - Any sample offered in the same cycle is not accepted; in_ready is forced to 0 while clear=1.
  - Any pending frame in HOLD is discarded.
- Priority: rst > clear > handshakes.
- ACC_LEN=1: every accepted sample produces a frame (HOLD each time).
- in_valid while in HOLD: the sample is not accepted and the upstream adder must hold its value. No data is lost.

Optional Feature:
- Macro: S_CSKA12_FRAME_ACCUM_SATURATE_EN.
- Defined:
  - On overflow, acc clamps to +(2^(ACC_W-1))-1 or -(2^(ACC_W-1)), chosen by the sign of the ACC_W+1 result.
  - Accumulation continues from the clamped value; ovf is still flagged.
- Undefined: wrap-around as above, with ovf flagging only.
- Port list is identical in both builds.

Test Plan:
- Basic frame:
  - Stimulus: ACC_LEN=4, out_ready=1, samples 100, -50, 4095, -4096 on consecutive cycles.
  - Response: acc_out=49, out_valid for 1 cycle, 1 cycle after the 4th accept; ovf=0; sample_cnt returns to 0.
- Overflow:
  - Stimulus: ACC_W=16, ACC_LEN=16, sixteen samples of +4095.
  - Response: wrap build gives acc_out=-16 (0xFFF0); SATURATE build gives 32767. ovf=1 in both.
  - Stimulus: sixteen samples of -4096.
  - Response: wrap gives 0; saturate gives -32768. ovf=1.
- Backpressure:
  - Stimulus: out_ready=0 for 10 cycles after frame completion, in_valid held at 1.
  - Response: in_ready=0 and acc_out stable throughout. After out_ready=1, exactly one handshake occurs, then the next frame starts from acc=0.
- Clear mid-frame:
  - Stimulus: 2 of 4 samples (10, 20) accepted, then clear=1 with in_valid=1 and sum_in=5; then samples 1, 2, 3, 4.
  - Response: the sample 5 is dropped; the next frame total is 10.
- Reset mid-HOLD:
  - Stimulus: rst=1 for one cycle while out_valid=1.
  - Response: out_valid=0, acc_out=0, sample_cnt=0, ovf=0 at the next edge; in_ready=1 afterwards.
- Gapped input:
  - Stimulus: ACC_LEN=3, samples -1, -1, -1 with in_valid idle cycles between them.
  - Response: acc_out=-3; sample_cnt advances only on accepts.

Source files
------------

// File: rtl/s_cska12_frame_accum_if.sv
// Handshake bundle between the carry-skip adder, the frame accumulator and its consumer.
// Pure wiring, no latency.
// in_ready/out_ready carry backpressure in each direction; clear travels with the upstream side.
`timescale 1ns/1ps
interface s_cska12_frame_accum_if #(
  parameter int IN_W  = 13,
  parameter int ACC_W = 16,
  parameter int CNT_W = 8
);
  logic                    clear;
  logic signed [IN_W-1:0]  sum_in;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [ACC_W-1:0] acc_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_W-1:0]        sample_cnt;
  logic                    ovf;

  // Driver side: adder feeding samples and the frame consumer accepting totals.
  modport master (
    output clear, sum_in, in_valid, out_ready,
    input  in_ready, acc_out, out_valid, sample_cnt, ovf
  );

  // Accumulator side.
  modport slave (
    input  clear, sum_in, in_valid, out_ready,
    output in_ready, acc_out, out_valid, sample_cnt, ovf
  );
endinterface

// File: rtl/s_cska12_frame_accum.sv
// Sums ACC_LEN signed adder outputs into one ACC_W-bit frame total with a sticky overflow flag.
// Latency: out_valid rises one cycle after the edge accepting the last sample of a frame.
// Backpressure: one frame buffered; in_ready drops while it waits for out_ready or while clear=1.
// Build option: define S_CSKA12_FRAME_ACCUM_SATURATE_EN to clamp instead of wrap on overflow.
`timescale 1ns/1ps
module s_cska12_frame_accum #(
  parameter int IN_W    = 13,
  parameter int ACC_W   = 16,
  parameter int ACC_LEN = 16,
  parameter int CNT_W   = 8
) (
  input logic                   clk,
  input logic                   rst,
  s_cska12_frame_accum_if.slave bus
);

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(ACC_LEN - 1);

  state_t           state, state_nxt;
  logic [ACC_W-1:0] acc, acc_nxt, acc_out_q;
  logic [CNT_W-1:0] cnt;
  logic             ovf_q;
  logic [ACC_W:0]   sum_wide;
  logic             ovf_det;
  logic             in_ready_c, out_valid_c;
  logic             accept, last, consume;

  assign accept  = bus.in_valid && in_ready_c;
  assign last    = (cnt == LAST_IDX);
  assign consume = out_valid_c && bus.out_ready;

  // Add one guard bit so the true sum is always representable, then test the guard against the sign.
  always_comb begin
    sum_wide = {acc[ACC_W-1], acc} + {{(ACC_W+1-IN_W){bus.sum_in[IN_W-1]}}, bus.sum_in};
    ovf_det  = (sum_wide[ACC_W] != sum_wide[ACC_W-1]);
`ifdef S_CSKA12_FRAME_ACCUM_SATURATE_EN
    if (ovf_det) acc_nxt = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else         acc_nxt = sum_wide[ACC_W-1:0];
`else
    acc_nxt = sum_wide[ACC_W-1:0];
`endif
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next state: abort wins, otherwise complete a frame or release it on the output handshake.
  always_comb begin
    state_nxt = state;
    if (bus.clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && last) state_nxt = HOLD;
        HOLD:    if (bus.out_ready)  state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // Handshake outputs decoded from state; clear blocks intake so the offered sample stays upstream.
  always_comb begin
    in_ready_c  = (state == ACCUM) && !bus.clear;
    out_valid_c = (state == HOLD);
  end

  // Datapath: running sum, sample count, captured total and the per-frame overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      acc_out_q <= '0;
      ovf_q     <= 1'b0;
    end else if (bus.clear) begin
      acc   <= '0;
      cnt   <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= ovf_q | ovf_det;
      if (last) begin
        acc_out_q <= acc_nxt;
        acc       <= '0;
        cnt       <= '0;
      end else begin
        acc <= acc_nxt;
        cnt <= cnt + 1'b1;
      end
    end else if (consume) begin
      ovf_q <= 1'b0;
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_c;
  assign bus.acc_out    = acc_out_q;
  assign bus.sample_cnt = cnt;
  assign bus.ovf        = ovf_q;

endmodule

// File: tb/tb_s_cska12_frame_accum.sv
// Bench for s_cska12_frame_accum: three instances (ACC_LEN 4, 16, 3) on one clock.
// Expected frames are queued by the stimulus and popped by a monitor on each output handshake.
// Direct checks cover reset, backpressure, clear and counter behaviour.
`timescale 1ns/1ps
module tb_s_cska12_frame_accum;
  localparam int IN_W  = 13;
  localparam int ACC_W = 16;
  localparam int CNT_W = 8;
  localparam int N     = 3;

`ifdef S_CSKA12_FRAME_ACCUM_SATURATE_EN
  localparam int OVF_POS = 32767;
  localparam int OVF_NEG = -32768;
`else
  localparam int OVF_POS = -16;
  localparam int OVF_NEG = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic signed [IN_W-1:0]  sum_d [N];
  logic                    vld_d [N];
  logic                    rdy_d [N];
  logic                    clr_d [N];
  logic signed [ACC_W-1:0] acc_o [N];
  logic                    ov_o  [N];
  logic                    ir_o  [N];
  logic                    ovf_o [N];
  logic [CNT_W-1:0]        cnt_o [N];

  for (genvar g = 0; g < N; g++) begin : gd
    s_cska12_frame_accum_if #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) bus ();
    s_cska12_frame_accum #(
      .IN_W(IN_W), .ACC_W(ACC_W), .ACC_LEN((g == 0) ? 4 : (g == 1) ? 16 : 3), .CNT_W(CNT_W)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
    );
    assign bus.sum_in    = sum_d[g];
    assign bus.in_valid  = vld_d[g];
    assign bus.out_ready = rdy_d[g];
    assign bus.clear     = clr_d[g];
    assign acc_o[g]      = bus.acc_out;
    assign ov_o[g]       = bus.out_valid;
    assign ir_o[g]       = bus.in_ready;
    assign ovf_o[g]      = bus.ovf;
    assign cnt_o[g]      = bus.sample_cnt;
  end

  typedef struct {
    int                      id;
    logic signed [ACC_W-1:0] acc;
    logic                    ovf;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic push(input int id, input int acc, input logic o);
    exp_t x;
    x.id  = id;
    x.acc = ACC_W'(acc);
    x.ovf = o;
    exp_q.push_back(x);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one sample and hold it until the DUT takes it (bounded wait).
  task automatic send(input int k, input int v);
    bit ok;
    ok = 1'b0;
    sum_d[k] = IN_W'(v);
    vld_d[k] = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      if (ir_o[k]) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout dut=%0d in_ready=0 required=1", k);
    end
    tick();
    vld_d[k] = 1'b0;
  endtask

  // Monitor: every output handshake must match the next queued frame.
  always @(negedge clk) begin
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        if (ov_o[k] && rdy_d[k]) begin
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame dut=%0d acc_out=%0d required=no_frame", k, acc_o[k]);
          end else begin
            e = exp_q.pop_front();
            check("frame_dut", k, e.id);
            check("frame_acc", acc_o[k], e.acc);
            check("frame_ovf", ovf_o[k], e.ovf);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation_time_exceeded required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int k = 0; k < N; k++) begin
      sum_d[k] = '0; vld_d[k] = 1'b0; rdy_d[k] = 1'b0; clr_d[k] = 1'b0;
    end
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", ov_o[0], 0);
    check("reset_acc_out", acc_o[0], 0);
    check("reset_sample_cnt", cnt_o[0], 0);
    check("reset_ovf", ovf_o[0], 0);
    check("reset_in_ready", ir_o[0], 1);
    tick();

    // Basic frame, ACC_LEN=4: 100-50+4095-4096 = 49
    rdy_d[0] = 1'b1;
    push(0, 49, 1'b0);
    send(0, 100); send(0, -50); send(0, 4095); send(0, -4096);
    @(negedge clk);
    check("basic_out_valid", ov_o[0], 1);
    check("basic_cnt_cleared", cnt_o[0], 0);
    @(negedge clk);
    check("basic_valid_one_cycle", ov_o[0], 0);
    check("basic_in_ready_back", ir_o[0], 1);
    tick();

    // Backpressure: frame 1+2+3+4=10 held while out_ready=0 and in_valid stays high
    rdy_d[0] = 1'b0;
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    sum_d[0] = 13'sd7;
    vld_d[0] = 1'b1;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check("bp_in_ready_low", ir_o[0], 0);
      check("bp_acc_stable", acc_o[0], 10);
      check("bp_out_valid_high", ov_o[0], 1);
      tick();
    end
    push(0, 10, 1'b0);
    rdy_d[0] = 1'b1;
    // Held sample 7 opens the next frame from zero: 7+1+1+1 = 10
    push(0, 10, 1'b0);
    send(0, 7);
    @(negedge clk);
    check("bp_new_frame_cnt", cnt_o[0], 1);
    tick();
    send(0, 1); send(0, 1); send(0, 1);
    tick(); tick();

    // Clear mid-frame: 10, 20 accepted, then clear with 5 offered; next frame 1+2+3+4
    send(0, 10); send(0, 20);
    @(negedge clk);
    check("clr_cnt_before", cnt_o[0], 2);
    tick();
    clr_d[0] = 1'b1;
    sum_d[0] = 13'sd5;
    vld_d[0] = 1'b1;
    @(negedge clk);
    check("clr_in_ready_low", ir_o[0], 0);
    tick();
    clr_d[0] = 1'b0;
    vld_d[0] = 1'b0;
    @(negedge clk);
    check("clr_cnt_after", cnt_o[0], 0);
    tick();
    push(0, 10, 1'b0);
    send(0, 1); send(0, 2); send(0, 3); send(0, 4);
    tick(); tick();

    // Overflow, positive: sixteen x 4095
    rdy_d[1] = 1'b1;
    push(1, OVF_POS, 1'b1);
    for (int i = 0; i < 9; i++) send(1, 4095);
    @(negedge clk);
    check("ovf_sticky_mid_frame", ovf_o[1], 1);
    check("ovf_cnt_mid_frame", cnt_o[1], 9);
    tick();
    for (int i = 0; i < 7; i++) send(1, 4095);
    tick();
    @(negedge clk);
    check("ovf_cleared_after_consume", ovf_o[1], 0);
    tick();

    // Overflow, negative: sixteen x -4096, held, then reset while out_valid=1
    rdy_d[1] = 1'b0;
    for (int i = 0; i < 16; i++) send(1, -4096);
    @(negedge clk);
    check("neg_out_valid", ov_o[1], 1);
    check("neg_acc_out", acc_o[1], OVF_NEG);
    check("neg_ovf", ovf_o[1], 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_hold_out_valid", ov_o[1], 0);
    check("rst_hold_acc_out", acc_o[1], 0);
    check("rst_hold_cnt", cnt_o[1], 0);
    check("rst_hold_ovf", ovf_o[1], 0);
    check("rst_hold_in_ready", ir_o[1], 1);
    tick();
    rdy_d[1] = 1'b1;

    // Gapped input, ACC_LEN=3: -1 x3 with idle cycles between
    rdy_d[2] = 1'b1;
    push(2, -3, 1'b0);
    send(2, -1);
    tick(); tick();
    @(negedge clk);
    check("gap_cnt_1", cnt_o[2], 1);
    tick();
    send(2, -1);
    tick(); tick(); tick();
    @(negedge clk);
    check("gap_cnt_2", cnt_o[2], 2);
    tick();
    send(2, -1);
    tick(); tick();
    @(negedge clk);
    check("gap_cnt_end", cnt_o[2], 0);

    tick(); tick();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
